// File: rtl/fir_unfold_pkg.sv
// Shared definitions for the 3-way unfolded FIR filter datapath.
// Imported by the filter, the data maker and the serial-to-parallel packer.
package fir_unfold_pkg;

  localparam int unsigned NBIT   = 9;
  localparam int unsigned UNFOLD = 3;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2
  } lane_cnt_e;

  typedef logic [NBIT-1:0] sample_t;

endpackage

// File: rtl/fir_unfold_packer.sv
// Serial-to-3-parallel packer feeding the unfolded FIR input lanes.
// Groups three accepted samples per VOUT strobe; FLUSH emits a zero-padded partial group.
module fir_unfold_packer
  import fir_unfold_pkg::*;
#(
  parameter int unsigned NBIT = fir_unfold_pkg::NBIT
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic [NBIT-1:0] DIN,
  input  logic            VIN,
  input  logic            FLUSH,
  output logic [NBIT-1:0] DOUT3k,
  output logic [NBIT-1:0] DOUT3k1,
  output logic [NBIT-1:0] DOUT3k2,
  output logic            VOUT,
  output logic [1:0]      PAD
);

  localparam logic [NBIT-1:0] Zero = '0;

  lane_cnt_e       cnt_q;
  logic [NBIT-1:0] hold0_q, hold1_q;
  logic [NBIT-1:0] dout0_q, dout1_q, dout2_q;
  logic            vout_q;
  logic [1:0]      pad_q;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      cnt_q   <= FILL0;
      hold0_q <= '0;
      hold1_q <= '0;
      dout0_q <= '0;
      dout1_q <= '0;
      dout2_q <= '0;
      vout_q  <= 1'b0;
      pad_q   <= 2'd0;
    end else begin
      vout_q <= 1'b0;
      if (VIN) begin
        // DIN is accepted first; a concurrent FLUSH then closes the group it lands in.
        case (cnt_q)
          FILL0: begin
            if (FLUSH) begin
              dout0_q <= DIN;
              dout1_q <= Zero;
              dout2_q <= Zero;
              pad_q   <= 2'd2;
              vout_q  <= 1'b1;
              cnt_q   <= FILL0;
            end else begin
              hold0_q <= DIN;
              cnt_q   <= FILL1;
            end
          end
          FILL1: begin
            if (FLUSH) begin
              dout0_q <= hold0_q;
              dout1_q <= DIN;
              dout2_q <= Zero;
              pad_q   <= 2'd1;
              vout_q  <= 1'b1;
              cnt_q   <= FILL0;
            end else begin
              hold1_q <= DIN;
              cnt_q   <= FILL2;
            end
          end
          FILL2: begin
            dout0_q <= hold0_q;
            dout1_q <= hold1_q;
            dout2_q <= DIN;
            pad_q   <= 2'd0;
            vout_q  <= 1'b1;
            cnt_q   <= FILL0;
          end
          default: cnt_q <= FILL0;
        endcase
      end else if (FLUSH) begin
        case (cnt_q)
          FILL1: begin
            dout0_q <= hold0_q;
            dout1_q <= Zero;
            dout2_q <= Zero;
            pad_q   <= 2'd2;
            vout_q  <= 1'b1;
            cnt_q   <= FILL0;
          end
          FILL2: begin
            dout0_q <= hold0_q;
            dout1_q <= hold1_q;
            dout2_q <= Zero;
            pad_q   <= 2'd1;
            vout_q  <= 1'b1;
            cnt_q   <= FILL0;
          end
          default: cnt_q <= FILL0;
        endcase
      end
    end
  end

  assign DOUT3k  = dout0_q;
  assign DOUT3k1 = dout1_q;
  assign DOUT3k2 = dout2_q;
  assign VOUT    = vout_q;
  assign PAD     = pad_q;

endmodule

// File: tb/tb_fir_unfold_packer.sv
// Randomized and directed bench for fir_unfold_packer against a queue-based group model.
module tb_fir_unfold_packer;

  localparam int unsigned NBIT = 9;

  logic            CLK = 1'b0;
  logic            RST_n;
  logic [NBIT-1:0] DIN;
  logic            VIN;
  logic            FLUSH;
  logic [NBIT-1:0] DOUT3k, DOUT3k1, DOUT3k2;
  logic            VOUT;
  logic [1:0]      PAD;

  int checks = 0;
  int errors = 0;

  // Reference state: samples accepted but not yet emitted, plus last emitted group.
  int unsigned pend[$];
  int unsigned exp_d0 = 0, exp_d1 = 0, exp_d2 = 0, exp_pad = 0;
  int unsigned exp_v = 0;
  int          vout_count = 0;

  fir_unfold_packer #(.NBIT(NBIT)) dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .DIN     (DIN),
    .VIN     (VIN),
    .FLUSH   (FLUSH),
    .DOUT3k  (DOUT3k),
    .DOUT3k1 (DOUT3k1),
    .DOUT3k2 (DOUT3k2),
    .VOUT    (VOUT),
    .PAD     (PAD)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare all outputs.
  task automatic step(input logic rst_n, input logic vin, input logic flush,
                      input int signed din);
    int unsigned n;
    RST_n = rst_n;
    VIN   = vin;
    FLUSH = flush;
    DIN   = din[NBIT-1:0];
    @(posedge CLK);
    #1;
    if (!rst_n) begin
      pend.delete();
      exp_v = 0; exp_d0 = 0; exp_d1 = 0; exp_d2 = 0; exp_pad = 0;
    end else begin
      exp_v = 0;
      if (vin) pend.push_back(int'(din[NBIT-1:0]));
      n = pend.size();
      if (n == 3 || (flush && n > 0)) begin
        exp_v   = 1;
        exp_pad = 3 - n;
        exp_d0  = pend[0];
        exp_d1  = (n > 1) ? pend[1] : 0;
        exp_d2  = (n > 2) ? pend[2] : 0;
        pend.delete();
      end
    end
    if (VOUT === 1'b1) vout_count++;
    check("vout", VOUT, exp_v);
    check("dout3k", DOUT3k, exp_d0);
    check("dout3k1", DOUT3k1, exp_d1);
    check("dout3k2", DOUT3k2, exp_d2);
    check("pad", PAD, exp_pad);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int cnt_before;
    RST_n = 1'b0; VIN = 1'b0; FLUSH = 1'b0; DIN = '0;

    // Reset sweep with VIN toggling.
    for (int i = 0; i < 3; i++) step(1'b0, i[0], 1'b0, 100 + i);
    cnt_before = vout_count;
    step(1'b1, 1'b1, 1'b0, 1);
    step(1'b1, 1'b1, 1'b0, 2);
    step(1'b1, 1'b1, 1'b0, 3);
    check("first_group_vout", VOUT, 1);
    check("first_group_lane0", DOUT3k, 1);
    idle(2);

    // Back-to-back negative/positive stream.
    cnt_before = vout_count;
    for (int s = -4; s <= 7; s++) step(1'b1, 1'b1, 1'b0, s);
    check("b2b_pulses", vout_count - cnt_before, 4);
    check("b2b_last_lane2", DOUT3k2, 7);
    idle(1);

    // Gapped input.
    cnt_before = vout_count;
    step(1'b1, 1'b1, 1'b0, 10); idle(2);
    step(1'b1, 1'b1, 1'b0, 20); idle(2);
    step(1'b1, 1'b1, 1'b0, 30);
    idle(2);
    check("gap_pulses", vout_count - cnt_before, 1);

    // Flush cases.
    step(1'b1, 1'b1, 1'b0, 5); step(1'b1, 1'b0, 1'b1, 0);
    check("flush1_pad", PAD, 2);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 5); step(1'b1, 1'b1, 1'b0, 6); step(1'b1, 1'b0, 1'b1, 0);
    check("flush2_pad", PAD, 1);
    cnt_before = vout_count;
    step(1'b1, 1'b0, 1'b1, 0); idle(1);
    check("flush_empty_pulses", vout_count - cnt_before, 0);
    step(1'b1, 1'b1, 1'b0, 7); step(1'b1, 1'b1, 1'b0, 8); step(1'b1, 1'b1, 1'b1, 9);
    check("flush_full_pad", PAD, 0);
    step(1'b1, 1'b1, 1'b1, -1);
    step(1'b1, 1'b1, 1'b0, 11); step(1'b1, 1'b1, 1'b1, 12);
    idle(1);

    // Mid-group reset.
    cnt_before = vout_count;
    step(1'b1, 1'b1, 1'b0, 1); step(1'b1, 1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 3); step(1'b1, 1'b1, 1'b0, 4); step(1'b1, 1'b1, 1'b0, 5);
    check("midreset_lane0", DOUT3k, 3);
    idle(1);
    check("midreset_pulses", vout_count - cnt_before, 1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 6) == 0), int'($urandom_range(0, 511)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_unfold_packer.md
Name: fir_unfold_packer

Overview:
- Serial-to-3-parallel packer that feeds the 3-way unfolded FIR_FILTER input interface.
- Accepts one sample per valid cycle on a serial stream and groups three consecutive samples x[3k], x[3k+1], x[3k+2] into one parallel word.
- Drives DOUT3k/DOUT3k1/DOUT3k2 with a single-cycle VOUT strobe, directly compatible with the filter's DIN3k/DIN3k1/DIN3k2/VIN.
- A FLUSH input zero-pads and emits an incomplete final group.

Parameters:
- NBIT, 9, sample width in bits (two's complement; passed through unchanged).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_n  in  1  synchronous active-low reset.
- DIN  in  NBIT  serial input sample.
- VIN  in  1  DIN valid; one sample accepted per cycle with VIN=1.
- FLUSH  in  1  emit the pending partial group, zero-padded.
- DOUT3k  out  NBIT  lane 0, sample 3k (first accepted of group).
- DOUT3k1  out  NBIT  lane 1, sample 3k+1.
- DOUT3k2  out  NBIT  lane 2, sample 3k+2.
- VOUT  out  1  one-cycle strobe: lanes hold a new group.
- PAD  out  2  number of zero-padded lanes in current group (0 when full); valid with VOUT.

Behaviour:
- Reset (RST_n=0 at clock edge):
  - DOUT3k, DOUT3k1, DOUT3k2 = 0; VOUT = 0; PAD = 0.
  - Lane counter = 0; holding registers = 0.
  - Reset mid-group discards the partial samples; no VOUT is produced for them.
- Lane counter states: FILL0 (0 held), FILL1 (1 held), FILL2 (2 held).
- VIN=1, FILL0: DIN -> hold0; go to FILL1.
- VIN=1, FILL1: DIN -> hold1; go to FILL2.
- VIN=1, FILL2:
  - Output regs load {hold0, hold1, DIN}; VOUT=1 next cycle; PAD=0.
  - Go to FILL0.
  - Latency: VOUT is high the cycle after the third sample's accepting edge.
- VIN=0 and FLUSH=0: state held; VOUT=0.
- Outputs are registered and hold their value between strobes; VOUT is high for exactly one cycle per group.
- FLUSH=1, VIN=0:
  - FILL0: no output; stay in FILL0.
  - FILL1: emit {hold0, 0, 0}, PAD=2; go to FILL0.
  - FILL2: emit {hold0, hold1, 0}, PAD=1; go to FILL0.
- FLUSH=1, VIN=1: DIN is accepted first, then the flush applies to the updated count.
  - FILL0: emit {DIN, 0, 0}, PAD=2.
  - FILL1: emit {hold0, DIN, 0}, PAD=1.
  - FILL2: normal full group, PAD=0.
  - All cases end in FILL0.
- Throughput: at most one group per 3 valid cycles in steady state, and never more than one VOUT per cycle. No backpressure is needed because the filter consumes a group every cycle.
- Data path is a pure pass-through: no arithmetic, no sign extension, bit-exact lanes.

Decomposition:
- Shared package fir_unfold_pkg holds:
  - NBIT default constant (9).
  - UNFOLD = 3.
  - Lane-count typedef (2-bit enumerated FILL0/FILL1/FILL2).
  - Sample typedef logic [NBIT-1:0].
- The filter, data_maker and this block all import it.
- No sub-module: a single module of counter, three holding registers and an output register. Expected ~150 lines.

Test Plan:
- Reset sweep: RST_n=0 for 3 cycles with VIN toggling -> all outputs 0, VOUT never 1. Release, feed 1,2,3 -> VOUT once with DOUT3k=1, DOUT3k1=2, DOUT3k2=3, PAD=0, one cycle after sample 3.
- Back-to-back stream: VIN=1 continuously with DIN = -4..7 (12 samples) -> 4 VOUT pulses every 3rd cycle; lanes (-4,-3,-2), (-1,0,1), (2,3,4), (5,6,7); negative values bit-exact (-4 = 9'h1FC).
- Gapped input: samples 10, 20, 30 with 2 idle cycles between each -> single VOUT with (10, 20, 30), one cycle after 30 is accepted; VOUT=0 during gaps; previous outputs held.
- Flush cases:
  - 5 then FLUSH alone -> (5, 0, 0), PAD=2.
  - 5, 6 then FLUSH alone -> (5, 6, 0), PAD=1.
  - FLUSH in FILL0 -> no VOUT.
  - FLUSH with VIN on 3rd sample 9 after 7, 8 -> (7, 8, 9), PAD=0, single VOUT.
- Mid-group reset: feed 1, 2, assert RST_n=0 for one cycle, then feed 3, 4, 5 -> only VOUT carries (3, 4, 5); 1 and 2 never appear.
- System loop: connect to FIR_FILTER with serial golden samples -> filter outputs match the serial reference model, lane order 3k/3k1/3k2 preserved.
